// File: rtl/pipe_mem_arb.sv
// Single-port memory arbiter between IFU and LSU with one outstanding transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module pipe_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ifu_req_valid_i,
  output logic                  ifu_req_ready_o,
  input  logic [ADDR_W-1:0]     ifu_req_addr_i,
  input  logic                  ifu_flush_i,
  output logic                  ifu_rsp_valid_o,
  output logic [DATA_W-1:0]     ifu_rsp_data_o,
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic [ADDR_W-1:0]     lsu_req_addr_i,
  input  logic                  lsu_req_we_i,
  input  logic [DATA_W-1:0]     lsu_req_wdata_i,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask_i,
  output logic                  lsu_rsp_valid_o,
  output logic [DATA_W-1:0]     lsu_rsp_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic [DATA_W-1:0]     mem_req_wdata_o,
  output logic [DATA_W/8-1:0]   mem_req_wmask_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_W-1:0]     mem_rsp_data_i,
  output logic                  busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic       OWN_IFU = 1'b0;
  localparam logic       OWN_LSU = 1'b1;

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic                drop_q, drop_d;
  logic                ifu_elig_s;
  logic                grant_lsu_s;
  logic                grant_ifu_s;
  logic                accept_s;
  logic                rsp_fire_s;

`ifdef MEM_ARB_RR_EN
  logic                last_q, last_d;
`endif

  // A flushed fetch is not eligible for a grant in the same cycle.
  always_comb begin
    ifu_elig_s  = ifu_req_valid_i & ~ifu_flush_i;
`ifdef MEM_ARB_RR_EN
    if (lsu_req_valid_i && ifu_elig_s) begin
      grant_lsu_s = (last_q == OWN_IFU);
    end else begin
      grant_lsu_s = lsu_req_valid_i;
    end
`else
    grant_lsu_s = lsu_req_valid_i;
`endif
    grant_ifu_s = ifu_elig_s & ~grant_lsu_s;
  end

  assign ifu_req_ready_o = (state_q == ST_IDLE) & grant_ifu_s;
  assign lsu_req_ready_o = (state_q == ST_IDLE) & grant_lsu_s;
  assign accept_s        = (state_q == ST_IDLE) & (grant_ifu_s | grant_lsu_s);
  assign rsp_fire_s      = (state_q == ST_WAIT) & mem_rsp_valid_i;

  // Next-state and transaction-field capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
          if (grant_lsu_s) begin
            owner_d = OWN_LSU;
            addr_d  = lsu_req_addr_i;
            we_d    = lsu_req_we_i;
            wdata_d = lsu_req_wdata_i;
            wmask_d = lsu_req_wmask_i;
          end else begin
            owner_d = OWN_IFU;
            addr_d  = ifu_req_addr_i;
            we_d    = 1'b0;
            wdata_d = {DATA_W{1'b0}};
            wmask_d = {(DATA_W/8){1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
        if (ifu_flush_i && (owner_q == OWN_IFU)) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
        if (ifu_flush_i && (owner_q == OWN_IFU)) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // Remember who won the most recent accept.
  always_comb begin
    if (accept_s) begin
      last_d = grant_lsu_s ? OWN_LSU : OWN_IFU;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer starts as LSU-last so IFU wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWN_LSU;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Transaction state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= {ADDR_W{1'b0}};
      we_q    <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      wmask_q <= {(DATA_W/8){1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      drop_q  <= drop_d;
    end
  end

  assign mem_req_valid_o = (state_q == ST_REQ);
  assign mem_req_addr_o  = addr_q;
  assign mem_req_we_o    = we_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;
  assign busy_o          = (state_q != ST_IDLE);

  // A flush in the response cycle drops the fetch just like an earlier one.
  assign ifu_rsp_valid_o = rsp_fire_s & (owner_q == OWN_IFU) & ~drop_q & ~ifu_flush_i;
  assign lsu_rsp_valid_o = rsp_fire_s & (owner_q == OWN_LSU);
  assign ifu_rsp_data_o  = mem_rsp_data_i;
  assign lsu_rsp_data_o  = mem_rsp_data_i;

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Directed self-checking bench for pipe_mem_arb: vector table plus hand sequences.
module tb_pipe_mem_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ifu_req_valid_i, ifu_req_ready_o, ifu_flush_i, ifu_rsp_valid_o;
  logic [31:0] ifu_req_addr_i, ifu_rsp_data_o;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_req_we_i, lsu_rsp_valid_o;
  logic [31:0] lsu_req_addr_i, lsu_req_wdata_i, lsu_rsp_data_o;
  logic [3:0]  lsu_req_wmask_i, mem_req_wmask_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o, mem_rsp_valid_i, busy_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o, mem_rsp_data_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  pipe_mem_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_req_addr_i(ifu_req_addr_i), .ifu_flush_i(ifu_flush_i),
    .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_data_o(ifu_rsp_data_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_we_i(lsu_req_we_i),
    .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_req_wmask_i(lsu_req_wmask_i),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic        flush;
    logic        we;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rsp;
    logic        exp_lsu;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_reqs();
    ifu_req_valid_i = 1'b0;
    lsu_req_valid_i = 1'b0;
    ifu_flush_i     = 1'b0;
  endtask

  // Called mid-cycle while in REQ: handshake, respond, return to IDLE.
  task automatic finish_txn(input logic is_lsu, input logic [31:0] rsp, input logic dropped);
    mem_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = rsp;
    #1;
    chk("lsu_rsp_valid", {31'd0, lsu_rsp_valid_o}, {31'd0, is_lsu});
    chk("ifu_rsp_valid", {31'd0, ifu_rsp_valid_o}, {31'd0, (!is_lsu && !dropped)});
    chk(is_lsu ? "lsu_rsp_data" : "ifu_rsp_data", is_lsu ? lsu_rsp_data_o : ifu_rsp_data_o, rsp);
    @(posedge clk_i);
    #1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = 32'hA5A5_0000;
    #1;
    chk("busy_after_rsp", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic set_vec(input int i, input logic iv, input logic lv, input logic fl, input logic we,
                         input logic [31:0] ia, input logic [31:0] la, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [31:0] rsp, input logic el);
    vecs[i].ifu_v = iv; vecs[i].lsu_v = lv; vecs[i].flush = fl; vecs[i].we = we;
    vecs[i].ifu_addr = ia; vecs[i].lsu_addr = la; vecs[i].wdata = wd; vecs[i].wmask = wm;
    vecs[i].rsp = rsp; vecs[i].exp_lsu = el;
  endtask

  initial begin
    logic        tie_a, tie_b;
    logic [31:0] ea, ed;
    logic        ew;
    logic [3:0]  em;
`ifdef MEM_ARB_RR_EN
    tie_a = 1'b0; tie_b = 1'b1;
`else
    tie_a = 1'b1; tie_b = 1'b1;
`endif
    set_vec(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0100, 32'h0, 4'h0, 32'h1111_1111, tie_a);
    set_vec(1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h8000_0104, 32'hCAFE_F00D, 4'h3, 32'h2222_2222, tie_b);
    set_vec(2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h8000_0108, 32'h0, 4'h0, 32'h3333_3333, tie_a);
    set_vec(3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 32'h0000_0413, 1'b0);
    set_vec(4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_2000, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1);
    set_vec(5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0020, 32'h8000_3000, 32'h1234_5678, 4'hC, 32'h4444_4444, 1'b1);
    set_vec(6, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 32'h5555_5555, 1'b1);

    rst_i = 1'b1;
    clear_reqs();
    ifu_req_addr_i = 32'h0; lsu_req_addr_i = 32'h0; lsu_req_we_i = 1'b0;
    lsu_req_wdata_i = 32'h0; lsu_req_wmask_i = 4'h0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'hA5A5_0000;
    #1;
    chk("rst_mem_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_addr", mem_req_addr_o, 32'd0);
    chk("rst_ready", {30'd0, ifu_req_ready_o, lsu_req_ready_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven arbitration and full transactions.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      ifu_req_valid_i = vecs[i].ifu_v;  lsu_req_valid_i = vecs[i].lsu_v;
      ifu_flush_i     = vecs[i].flush;  lsu_req_we_i    = vecs[i].we;
      ifu_req_addr_i  = vecs[i].ifu_addr; lsu_req_addr_i = vecs[i].lsu_addr;
      lsu_req_wdata_i = vecs[i].wdata;  lsu_req_wmask_i = vecs[i].wmask;
      #1;
      chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_req_ready_o}, {31'd0, vecs[i].exp_lsu});
      chk($sformatf("v%0d_ifu_ready", i), {31'd0, ifu_req_ready_o}, {31'd0, !vecs[i].exp_lsu});
      @(posedge clk_i);
      #1;
      clear_reqs();
      ea = vecs[i].exp_lsu ? vecs[i].lsu_addr : vecs[i].ifu_addr;
      ew = vecs[i].exp_lsu ? vecs[i].we : 1'b0;
      ed = vecs[i].exp_lsu ? vecs[i].wdata : 32'h0;
      em = vecs[i].exp_lsu ? vecs[i].wmask : 4'h0;
      #1;
      chk($sformatf("v%0d_mem_valid", i), {31'd0, mem_req_valid_o}, 32'd1);
      chk($sformatf("v%0d_addr", i), mem_req_addr_o, ea);
      chk($sformatf("v%0d_we", i), {31'd0, mem_req_we_o}, {31'd0, ew});
      chk($sformatf("v%0d_wdata", i), mem_req_wdata_o, ed);
      chk($sformatf("v%0d_wmask", i), {28'd0, mem_req_wmask_o}, {28'd0, em});
      chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, 32'd1);
      finish_txn(vecs[i].exp_lsu, vecs[i].rsp, 1'b0);
    end

    // LSU store with memory stalling for three cycles.
    @(negedge clk_i);
    lsu_req_valid_i = 1'b1; lsu_req_we_i = 1'b1; lsu_req_addr_i = 32'h8000_1000;
    lsu_req_wdata_i = 32'hDEAD_BEEF; lsu_req_wmask_i = 4'hF;
    @(posedge clk_i);
    #1;
    clear_reqs();
    lsu_req_wdata_i = 32'h0; lsu_req_addr_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_valid", {31'd0, mem_req_valid_o}, 32'd1);
      chk("stall_addr", mem_req_addr_o, 32'h8000_1000);
      chk("stall_wdata", mem_req_wdata_o, 32'hDEAD_BEEF);
      chk("stall_we_mask", {27'd0, mem_req_we_o, mem_req_wmask_o}, 32'h1F);
      chk("stall_busy", {31'd0, busy_o}, 32'd1);
      @(posedge clk_i);
      #1;
    end
    finish_txn(1'b1, 32'h0000_0000, 1'b0);

    // Flush while waiting for a fetch response, then a normal fetch.
    @(negedge clk_i);
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h8000_0010;
    @(posedge clk_i);
    #1;
    clear_reqs();
    mem_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_req_ready_i = 1'b0; ifu_flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    ifu_flush_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h1234_5678;
    #1;
    chk("flushed_ifu_rsp", {31'd0, ifu_rsp_valid_o}, 32'd0);
    chk("flushed_lsu_rsp", {31'd0, lsu_rsp_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("flushed_busy", {31'd0, busy_o}, 32'd0);
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h8000_0014;
    #1;
    chk("post_flush_ready", {31'd0, ifu_req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    clear_reqs();
    finish_txn(1'b0, 32'h0010_0073, 1'b0);

    // Flush coinciding with the response drops it.
    @(negedge clk_i);
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h8000_0018;
    @(posedge clk_i);
    #1;
    clear_reqs();
    mem_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_req_ready_i = 1'b0; ifu_flush_i = 1'b1; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h7777_7777;
    #1;
    chk("same_cycle_flush_rsp", {31'd0, ifu_rsp_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    ifu_flush_i = 1'b0; mem_rsp_valid_i = 1'b0;
    #1;
    chk("same_cycle_flush_busy", {31'd0, busy_o}, 32'd0);

    // Flush in IDLE blocks the fetch for one cycle only.
    @(negedge clk_i);
    ifu_req_valid_i = 1'b1; ifu_flush_i = 1'b1; ifu_req_addr_i = 32'h8000_0040;
    #1;
    chk("idle_flush_ready", {31'd0, ifu_req_ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("idle_flush_no_accept", {31'd0, busy_o}, 32'd0);
    ifu_flush_i = 1'b0;
    #1;
    chk("idle_flush_next_ready", {31'd0, ifu_req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    clear_reqs();
    #1;
    chk("idle_flush_addr", mem_req_addr_o, 32'h8000_0040);
    finish_txn(1'b0, 32'h0000_0013, 1'b0);

    // Reset during REQ, then a stray response.
    @(negedge clk_i);
    lsu_req_valid_i = 1'b1; lsu_req_we_i = 1'b1; lsu_req_addr_i = 32'h8000_5000;
    lsu_req_wdata_i = 32'h0F0F_0F0F; lsu_req_wmask_i = 4'h5;
    @(posedge clk_i);
    #1;
    clear_reqs();
    #1;
    chk("pre_rst_valid", {31'd0, mem_req_valid_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, mem_req_valid_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_addr", mem_req_addr_o, 32'd0);
    chk("mid_rst_wdata", mem_req_wdata_o, 32'd0);
    chk("mid_rst_we_mask", {27'd0, mem_req_we_o, mem_req_wmask_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h9999_9999;
    #1;
    chk("stray_lsu_rsp", {31'd0, lsu_rsp_valid_o}, 32'd0);
    chk("stray_ifu_rsp", {31'd0, ifu_rsp_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("stray_busy", {31'd0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arb.md
# pipe_mem_arb

Single-port memory arbiter and transaction sequencer between the fetch stage (IFU) and the load/store unit (LSU) of the pipelined core. It accepts one request at a time from either requester and drives it onto the shared memory port with a valid/ready handshake. It tracks the single outstanding transaction and routes the response back to its owner. A fetch that is flushed while in flight has its response silently discarded.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ifu_req_valid_i / ifu_req_ready_o  in/out  1  fetch request handshake
- ifu_req_addr_i  in  ADDR_W  fetch PC
- ifu_flush_i  in  1  pipeline flush; kills in-flight fetch
- ifu_rsp_valid_o  out  1  fetch response strobe
- ifu_rsp_data_o  out  DATA_W  instruction
- lsu_req_valid_i / lsu_req_ready_o  in/out  1  load/store request handshake
- lsu_req_addr_i  in  ADDR_W  address
- lsu_req_we_i  in  1  1 = store
- lsu_req_wdata_i  in  DATA_W  store data
- lsu_req_wmask_i  in  DATA_W/8  byte mask
- lsu_rsp_valid_o  out  1  load/store completion strobe
- lsu_rsp_data_o  out  DATA_W  load data (don't-care for stores)
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake
- mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_wmask_o  out  per above  registered request fields
- mem_rsp_valid_i  in  1  memory response strobe
- mem_rsp_data_i  in  DATA_W  memory read data
- busy_o  out  1  state != IDLE

## Operation
- FSM states are IDLE, REQ and WAIT.
- IDLE:
  - The grant is computed combinationally.
  - Default priority is fixed: LSU over IFU.
  - Granted requester sees ready=1 in the same cycle. Only one ready is high per cycle.
  - On valid&ready: latch owner, addr, we, wdata and wmask, clear drop_q, then go to REQ.
  - IFU fields latch as we=0, wmask=0, wdata=0.
- REQ:
  - mem_req_valid_o=1 with the latched fields, held stable until mem_req_ready_i.
  - A request cannot be withdrawn.
  - mem_req_ready_i=1 -> WAIT.
- WAIT:
  - On mem_rsp_valid_i, the owner's rsp_valid_o=1 for that cycle and rsp_data_o=mem_rsp_data_i (combinational pass-through). Then go to IDLE.
  - If owner=IFU and drop_q=1 (or ifu_flush_i=1 in that cycle), ifu_rsp_valid_o stays 0. The response is consumed and the FSM still returns to IDLE.
- Flush:
  - ifu_flush_i in REQ or WAIT with owner=IFU sets drop_q.
  - ifu_flush_i in IDLE forces ifu_req_ready_o=0 for that cycle.
  - Flush has no effect on LSU transactions.
- mem_rsp_valid_i outside WAIT is ignored.
- ready outputs are 0 in REQ and WAIT.
- *_rsp_data_o is driven from mem_rsp_data_i at all times. Consumers qualify it with rsp_valid_o.

## Timing
- Reset values:
  - FSM state = IDLE.
  - All valid and ready outputs = 0, except that the ready of the granted requester follows the IDLE grant logic.
  - mem_req_addr_o, mem_req_wdata_o and mem_req_wmask_o = 0; mem_req_we_o = 0.
  - drop_q = 0; busy_o = 0.
  - RR pointer = LSU-last.
- Accept happens at cycle N. mem_req_valid_o rises at N+1.
- With mem_req_ready_i=1 at N+1 and mem_rsp_valid_i=1 at N+2, the response strobe is at N+2. Best-case latency from accept to response is 2 cycles.
- The next accept is possible at N+3. Throughput is at most one transaction per 3 cycles.
- Reset mid-transaction returns to IDLE immediately; the in-flight response is lost. The memory side must be reset together with this block.
- Simultaneous flush and mem_rsp_valid_i in WAIT with owner=IFU: the response is dropped.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant register updates on every accept.
  - On a tie, the requester not granted last wins.
  - After reset, IFU wins the first tie.
- MEM_ARB_RR_EN undefined: fixed LSU-over-IFU priority and no pointer register.

## Test plan
- IFU alone, addr 0x80000000, mem ready immediately, rsp 0x00000413 one cycle later -> ifu_rsp_valid_o pulses at accept+2 with data 0x00000413; lsu_rsp_valid_o stays 0.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, mask 0xF, mem_req_ready_i low for 3 cycles -> mem_req fields stable for all 3 cycles, we=1, busy_o=1 throughout, lsu_rsp_valid_o on the response.
- IFU and LSU valid together every cycle:
  - Fixed mode: LSU always granted.
  - MEM_ARB_RR_EN: grants alternate IFU, LSU, IFU, ...
- IFU fetch in WAIT, ifu_flush_i pulsed, then mem rsp 0x12345678 -> no ifu_rsp_valid_o, FSM back to IDLE, next IFU request accepted normally.
- ifu_flush_i asserted in IDLE with ifu_req_valid_i=1 -> ifu_req_ready_o=0 that cycle, accept occurs the next cycle.
- rst_i asserted during REQ -> outputs at reset values immediately; a stray mem_rsp_valid_i afterwards produces no response strobe.
